// File: rtl/barrel_aligner.sv
// Purpose : finds the bit rotation of a framing sync byte in a rotated byte stream,
//           locks to it and emits de-rotated payload bytes with start-of-frame markers.
// Latency : 1 clock from a sampled input byte to o/ov/sof; no backpressure (v qualifies every step).
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   i     rotated input byte, qualified by v
//   v     input byte valid; nothing advances on v=0
//   o     de-rotated payload byte (holds when ov=0)
//   ov    one-cycle pulse per payload byte
//   sof   marks the first payload byte of each frame (with ov)
//   lock  high while locked to a rotation
//   k     left-rotate amount applied, o = rotl(i, k)

module barrel_aligner #(
    parameter logic [7:0] SYNC      = 8'hA5,
    parameter int         FRAME_LEN = 8,
    parameter int         CONFIRM_N = 3,
    parameter int         MISS_N    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i,
    input  logic       v,
    output logic [7:0] o,
    output logic       ov,
    output logic       sof,
    output logic       lock,
    output logic [2:0] k
);

    localparam int POS_W  = $clog2(FRAME_LEN);
    localparam int HIT_W  = $clog2(CONFIRM_N + 1);
    localparam int MISS_W = $clog2(MISS_N + 1);

    localparam logic [POS_W-1:0]  POS_ZERO  = '0;
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [HIT_W-1:0]  HITS_LOCK = HIT_W'(CONFIRM_N);
    localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(MISS_N);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Left rotate: shifting the doubled byte brings the wrapped bits in from below.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    logic [1:0]        state_q, state_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic [HIT_W-1:0]  hits_q,  hits_d;
    logic [MISS_W-1:0] misses_q, misses_d;
    logic [2:0]        k_q,     k_d;
    logic [7:0]        o_q,     o_d;
    logic              ov_q,    ov_d;
    logic              sof_q,   sof_d;

    // Search of all eight rotations, used only while hunting.
    logic [7:0] match;
    logic       hunt_found;
    logic [2:0] hunt_k;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            match[n] = (rotl8(i, 3'(n)) == SYNC);
        end
    end

    // Lowest matching rotation wins; with an aperiodic sync at most one bit is set.
    always_comb begin
        hunt_k = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (match[n]) begin
                hunt_k = 3'(n);
            end
        end
    end

    assign hunt_found = |match;

    // Datapath under the current rotation, used once a candidate k exists.
    logic [7:0]        rot_byte;
    logic              sync_hit;
    logic [POS_W-1:0]  pos_nxt;
    logic [HIT_W-1:0]  hits_inc;
    logic [MISS_W-1:0] misses_inc;

    assign rot_byte   = rotl8(i, k_q);
    assign sync_hit   = (rot_byte == SYNC);
    assign pos_nxt    = (pos_q == POS_LAST) ? POS_ZERO : pos_q + POS_ONE;
    assign hits_inc   = hits_q + HIT_W'(1);
    assign misses_inc = misses_q + MISS_W'(1);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        k_d      = k_q;
        o_d      = o_q;
        ov_d     = 1'b0;
        sof_d    = 1'b0;

        if (v) begin
            case (state_q)
                ST_HUNT: begin
                    if (hunt_found) begin
                        k_d    = hunt_k;
                        hits_d = HIT_W'(1);
                        pos_d  = POS_ONE;
                        // The sync byte that opens the search is never output.
                        if (CONFIRM_N == 1) begin
                            state_d  = ST_LOCKED;
                            misses_d = '0;
                        end else begin
                            state_d  = ST_CONFIRM;
                        end
                    end
                end

                ST_CONFIRM: begin
                    if (pos_q != POS_ZERO) begin
                        pos_d = pos_nxt;
                    end else if (sync_hit) begin
                        pos_d  = pos_nxt;
                        hits_d = hits_inc;
                        if (hits_inc == HITS_LOCK) begin
                            state_d  = ST_LOCKED;
                            misses_d = '0;
                        end
                    end else begin
                        // Candidate rotation rejected; the failing byte is not searched again.
                        state_d = ST_HUNT;
                        hits_d  = '0;
                        pos_d   = POS_ZERO;
                    end
                end

                ST_LOCKED: begin
                    if (pos_q != POS_ZERO) begin
                        pos_d = pos_nxt;
                        o_d   = rot_byte;
                        ov_d  = 1'b1;
                        sof_d = (pos_q == POS_ONE);
                    end else if (sync_hit) begin
                        pos_d    = pos_nxt;
                        misses_d = '0;
                    end else if (misses_inc == MISS_DROP) begin
                        state_d  = ST_HUNT;
                        pos_d    = POS_ZERO;
                        hits_d   = '0;
                        misses_d = '0;
                    end else begin
                        // Tolerated miss: frame timing and k are kept.
                        pos_d    = pos_nxt;
                        misses_d = misses_inc;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    pos_d   = POS_ZERO;
                    hits_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            k_q      <= 3'd0;
            o_q      <= 8'h00;
            ov_q     <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            k_q      <= k_d;
            o_q      <= o_d;
            ov_q     <= ov_d;
            sof_q    <= sof_d;
        end
    end

    assign o    = o_q;
    assign ov   = ov_q;
    assign sof  = sof_q;
    assign k    = k_q;
    assign lock = (state_q == ST_LOCKED);

endmodule
